hemaia_clk_div_update_sequencer: RTL and testbench



---
 rtl/hemaia_clk_div_update_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_hemaia_clk_div_update_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hemaia_clk_div_update_sequencer.sv
// Glitch-free runtime divisor update sequencer: gate, hold, load, settle, ungate.
// Optional HEMAIA_CLK_DIV_RAMP_EN: walk the divisor one step per load instead of jumping.
module hemaia_clk_div_update_sequencer #(
    parameter int unsigned MaxDivisionWidth = 8,
    parameter int unsigned DefaultDivision  = 1,
    parameter int unsigned GateHoldCycles   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [MaxDivisionWidth-1:0] req_divisor_i,
    input  logic                        req_valid_i,
    output logic [MaxDivisionWidth-1:0] divisor_o,
    output logic                        divisor_valid_o,
    output logic                        clk_en_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int unsigned W = MaxDivisionWidth;
    localparam logic [W-1:0] DefDiv = (DefaultDivision == 0) ? W'(1) : W'(DefaultDivision);
    localparam int unsigned GateCntW = (GateHoldCycles > 1) ? $clog2(GateHoldCycles) : 1;
    localparam logic [GateCntW-1:0] GateLast = GateCntW'(GateHoldCycles - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GATE   = 3'd1,
        LOAD   = 3'd2,
        SETTLE = 3'd3,
        STEP   = 3'd4
    } state_e;

    state_e                state_q;
    logic                  req_prev_q;
    logic                  req_pulse_q;
    logic [W-1:0]          req_tgt_q;
    logic [GateCntW-1:0]   gate_cnt_q;
    logic [W:0]            settle_cnt_q;
    logic [W-1:0]          target_q;
    logic                  pend_valid_q;
    logic [W-1:0]          pend_tgt_q;
    logic [W-1:0]          divisor_q;
    logic                  div_valid_q;
    logic                  clk_en_q;
    logic                  busy_q;
    logic                  done_q;

    logic [W-1:0] req_clamped;
    logic         pend_any;
    logic [W-1:0] pend_tgt;
    logic [W:0]   settle_last;
    logic [W-1:0] load_div;

    assign req_clamped = (req_divisor_i == '0) ? W'(1) : req_divisor_i;

    // A request arriving in the same cycle overrides the stored one (latest wins).
    assign pend_any    = pend_valid_q | req_pulse_q;
    assign pend_tgt    = req_pulse_q ? req_tgt_q : pend_tgt_q;

    // Settle lasts 2*divisor cycles; divisor is never 0 so this cannot underflow.
    assign settle_last = {divisor_q, 1'b0} - (W+1)'(1);

`ifdef HEMAIA_CLK_DIV_RAMP_EN
    logic [W-1:0] step_tgt;
    assign step_tgt = pend_any ? pend_tgt : target_q;
    assign load_div = (divisor_q < target_q) ? divisor_q + W'(1) :
                      (divisor_q > target_q) ? divisor_q - W'(1) : divisor_q;
`else
    assign load_div = target_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            req_prev_q   <= 1'b0;
            req_pulse_q  <= 1'b0;
            req_tgt_q    <= '0;
            gate_cnt_q   <= '0;
            settle_cnt_q <= '0;
            target_q     <= DefDiv;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= '0;
            divisor_q    <= DefDiv;
            div_valid_q  <= 1'b0;
            clk_en_q     <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            req_prev_q  <= req_valid_i;
            req_pulse_q <= req_valid_i & ~req_prev_q;
            if (req_valid_i && !req_prev_q) begin
                req_tgt_q <= req_clamped;
            end
            div_valid_q <= 1'b0;
            done_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (pend_any) begin
                        pend_valid_q <= 1'b0;
                        if (pend_tgt == divisor_q) begin
                            done_q <= 1'b1;
                        end else begin
                            target_q   <= pend_tgt;
                            state_q    <= GATE;
                            gate_cnt_q <= '0;
                            clk_en_q   <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                GATE: begin
                    if (req_pulse_q) begin
                        pend_valid_q <= 1'b1;
                        pend_tgt_q   <= req_tgt_q;
                    end
                    if (gate_cnt_q == GateLast) begin
                        state_q     <= LOAD;
                        divisor_q   <= load_div;
                        div_valid_q <= 1'b1;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + GateCntW'(1);
                    end
                end
                LOAD: begin
                    if (req_pulse_q) begin
                        pend_valid_q <= 1'b1;
                        pend_tgt_q   <= req_tgt_q;
                    end
                    state_q      <= SETTLE;
                    settle_cnt_q <= '0;
                end
                SETTLE: begin
                    if (settle_cnt_q != settle_last) begin
                        settle_cnt_q <= settle_cnt_q + (W+1)'(1);
                        if (req_pulse_q) begin
                            pend_valid_q <= 1'b1;
                            pend_tgt_q   <= req_tgt_q;
                        end
                    end else begin
                        pend_valid_q <= 1'b0;
`ifdef HEMAIA_CLK_DIV_RAMP_EN
                        target_q <= step_tgt;
                        clk_en_q <= 1'b1;
                        if (divisor_q == step_tgt) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= STEP;
                        end
`else
                        done_q <= 1'b1;
                        if (pend_any) begin
                            // Chain straight into the queued update without ungating.
                            target_q   <= pend_tgt;
                            state_q    <= GATE;
                            gate_cnt_q <= '0;
                        end else begin
                            state_q  <= IDLE;
                            clk_en_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end
`endif
                    end
                end
`ifdef HEMAIA_CLK_DIV_RAMP_EN
                STEP: begin
                    if (req_pulse_q) begin
                        pend_valid_q <= 1'b1;
                        pend_tgt_q   <= req_tgt_q;
                    end
                    state_q    <= GATE;
                    gate_cnt_q <= '0;
                    clk_en_q   <= 1'b0;
                end
`endif
                default: begin
                    state_q  <= IDLE;
                    clk_en_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign divisor_o       = divisor_q;
    assign divisor_valid_o = div_valid_q;
    assign clk_en_o        = clk_en_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_hemaia_clk_div_update_sequencer.sv
// Bench for hemaia_clk_div_update_sequencer: sequence-level timing model, random and directed requests.
module tb_hemaia_clk_div_update_sequencer;

    localparam int W    = 8;
    localparam int G    = 4;
    localparam int MAXN = 600;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] req_div;
    logic         req_valid;
    logic [W-1:0] div_o;
    logic         dv_o, clken_o, busy_o, done_o;

    always #5 clk = ~clk;

    hemaia_clk_div_update_sequencer #(
        .MaxDivisionWidth(W),
        .DefaultDivision (0),
        .GateHoldCycles  (G)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_divisor_i  (req_div),
        .req_valid_i    (req_valid),
        .divisor_o      (div_o),
        .divisor_valid_o(dv_o),
        .clk_en_o       (clken_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic         lvl  [MAXN];
    logic [W-1:0] dsel [MAXN];
    logic [W-1:0] e_div[MAXN];
    logic         e_dv [MAXN], e_clk[MAXN], e_busy[MAXN], e_done[MAXN];
    logic         o_clk[MAXN], o_dv[MAXN], o_done[MAXN];
    logic [W-1:0] o_div[MAXN];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int cyc);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Expected outputs after edge k, derived per sequence: start a, load a+G, end a+G+1+2D.
    task automatic build_model(input int n);
        int           act_q[$];
        logic [W-1:0] tgt_q[$];
        logic [W-1:0] cur, t;
        int           i, a, s, ld, e;
        bit           chained;
        cur = 1;
        for (int k = 0; k < n; k++) begin
            e_div[k] = 1; e_dv[k] = 0; e_clk[k] = 1; e_busy[k] = 0; e_done[k] = 0;
        end
        for (int k = 0; k < n; k++) begin
            if (lvl[k] && (k == 0 || !lvl[k-1])) begin
                act_q.push_back(k + 1);
                tgt_q.push_back((dsel[k] == 0) ? W'(1) : dsel[k]);
            end
        end
        i = 0;
        while (i < act_q.size()) begin
            a = act_q[i]; t = tgt_q[i]; i++;
            if (t == cur) begin
                if (a < n) e_done[a] = 1;
                continue;
            end
            s = a;
            chained = 1;
            while (chained) begin
                ld = s + G;
                e  = ld + 1 + 2 * int'(t);
                for (int k = s; k < e && k < n; k++) begin
                    e_clk[k] = 0; e_busy[k] = 1;
                end
                if (ld < n) e_dv[ld] = 1;
                for (int k = ld; k < n; k++) e_div[k] = t;
                cur = t;
                if (e < n) e_done[e] = 1;
                chained = 0;
                while (i < act_q.size() && act_q[i] <= e) begin
                    t = tgt_q[i]; i++; chained = 1;
                end
                s = e;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 0; req_valid = 0; req_div = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_phase(input int n);
        build_model(n);
        do_reset();
        rst_n = 1; req_valid = lvl[0]; req_div = dsel[0];
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            o_clk[k] = clken_o; o_dv[k] = dv_o; o_div[k] = div_o; o_done[k] = done_o;
            check("divisor_o", div_o, e_div[k], k);
            check("divisor_valid_o", dv_o, e_dv[k], k);
            check("clk_en_o", clken_o, e_clk[k], k);
            check("busy_o", busy_o, e_busy[k], k);
            check("done_o", done_o, e_done[k], k);
            if (k + 1 < n) begin
                req_valid = lvl[k+1]; req_div = dsel[k+1];
            end
        end
    endtask

    task automatic clear_stim(input int n);
        for (int k = 0; k < n; k++) begin
            lvl[k] = 0; dsel[k] = 0;
        end
    endtask

    initial begin
        int lows, nloads, first_dv, second_val, done_at;

        // Reset values with DefaultDivision=0
        do_reset();
        check("rst_divisor", div_o, 1, 0);
        check("rst_clk_en", clken_o, 1, 0);
        check("rst_busy", busy_o, 0, 0);
        check("rst_dv", dv_o, 0, 0);
        check("rst_done", done_o, 0, 0);

        // Request 4 from 1
        clear_stim(30);
        lvl[0] = 1; lvl[1] = 1; lvl[2] = 1;
        dsel[0] = 4; dsel[1] = 4; dsel[2] = 4;
        run_phase(30);
        lows = 0; first_dv = -1; done_at = -1;
        for (int k = 0; k < 30; k++) begin
            if (!o_clk[k]) lows++;
            if (o_dv[k] && first_dv < 0) first_dv = k;
            if (o_done[k] && done_at < 0) done_at = k;
        end
        check("t1_low_cycles", lows, 13, 0);
        check("t1_load_cycle", first_dv, 5, 0);
        check("t1_load_value", (first_dv >= 0) ? int'(o_div[first_dv]) : -1, 4, 0);
        check("t1_done_cycle", done_at, 14, 0);

        // Level held high 20 cycles, then a fresh 0->1 transition
        clear_stim(60);
        for (int k = 0; k < 20; k++) begin lvl[k] = 1; dsel[k] = 5; end
        for (int k = 25; k < 31; k++) begin lvl[k] = 1; dsel[k] = 2; end
        run_phase(60);
        nloads = 0;
        for (int k = 0; k < 60; k++) if (o_dv[k]) nloads++;
        check("t2_load_count", nloads, 2, 0);

        // Request 4, then 6 and 3 during GATE: 6 is never loaded
        clear_stim(50);
        lvl[0] = 1; dsel[0] = 4;
        lvl[2] = 1; dsel[2] = 6;
        lvl[4] = 1; dsel[4] = 3;
        run_phase(50);
        nloads = 0; second_val = -1;
        for (int k = 0; k < 50; k++) begin
            if (o_dv[k]) begin
                nloads++;
                if (nloads == 2) second_val = int'(o_div[k]);
            end
        end
        check("t3_load_count", nloads, 2, 0);
        check("t3_second_load", second_val, 3, 0);

        // Request 0 while divisor is 1: done after one cycle, no gating
        clear_stim(12);
        lvl[0] = 1; dsel[0] = 0;
        run_phase(12);
        lows = 0;
        for (int k = 0; k < 12; k++) if (!o_clk[k]) lows++;
        check("t4_no_gating", lows, 0, 0);
        check("t4_done_cycle", o_done[1], 1, 1);

        // Randomized requests with a quiet tail so every sequence completes
        lvl[0] = 0;
        for (int k = 0; k < 440; k++) begin
            if (k > 0) lvl[k] = ($urandom_range(0, 5) == 0) ? ~lvl[k-1] : lvl[k-1];
            else lvl[k] = $urandom_range(0, 1);
            dsel[k] = W'($urandom_range(0, 6));
            if (k >= 400) lvl[k] = 0;
        end
        run_phase(440);

        // Reset in the middle of SETTLE with a pending request
        do_reset();
        rst_n = 1; req_valid = 1; req_div = 8;
        @(posedge clk); #1; req_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1; req_valid = 1; req_div = 5;
        repeat (7) @(posedge clk);
        #1;
        check("t5_busy_in_settle", busy_o, 1, 9);
        check("t5_divisor_loaded", div_o, 8, 9);
        rst_n = 0; req_valid = 0;
        @(posedge clk); #1;
        check("t5_rst_divisor", div_o, 1, 10);
        check("t5_rst_clk_en", clken_o, 1, 10);
        check("t5_rst_busy", busy_o, 0, 10);
        check("t5_rst_dv", dv_o, 0, 10);
        check("t5_rst_done", done_o, 0, 10);
        rst_n = 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            check("t5_idle_busy", busy_o, 0, 11 + k);
            check("t5_idle_clk_en", clken_o, 1, 11 + k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish within bound");
        $fatal(1, "timeout");
    end

endmodule
